// File: rtl/dwt4db_analysis_pkg.sv
// rtl/dwt4db_analysis_pkg.sv - shared db3 Q8 constants, widths and result helpers
package dwt4db_analysis_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 24;
  localparam int ACC_W    = 26;
  localparam int QSHIFT   = 8;

  localparam int H0 = 85;
  localparam int H1 = 207;
  localparam int H2 = 118;
  localparam int H3 = -35;
  localparam int H4 = -22;
  localparam int H5 = 9;

  localparam int G0 = 9;
  localparam int G1 = 22;
  localparam int G2 = -35;
  localparam int G3 = -118;
  localparam int G4 = 207;
  localparam int G5 = -85;

  // g is a sign-flipped reversal of h, so six magnitudes cover both filters
  typedef struct packed {
    logic signed [PROD_W-1:0] p9;
    logic signed [PROD_W-1:0] p22;
    logic signed [PROD_W-1:0] p35;
    logic signed [PROD_W-1:0] p85;
    logic signed [PROD_W-1:0] p118;
    logic signed [PROD_W-1:0] p207;
  } rag_t;

  function automatic logic signed [ACC_W-1:0] ext(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> QSHIFT;
    if (s > 26'sd32767)
      return 16'sh7fff;
    else if (s < -26'sd32768)
      return 16'sh8000;
    return s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/dwt4db_analysis_rag4db.sv
// rtl/dwt4db_analysis_rag4db.sv - shift-add constant multiplier for the db3 Q8 magnitudes
module rag4db
  import dwt4db_analysis_pkg::*;
(
  input  logic [15:0] x,
  output rag_t        p
);

  logic signed [PROD_W-1:0] x1, x3, x5, x9;

  assign x1 = {{(PROD_W-SAMPLE_W){x[15]}}, x};
  assign x3 = (x1 <<< 1) + x1;
  assign x5 = (x1 <<< 2) + x1;
  assign x9 = (x1 <<< 3) + x1;

  assign p.p9   = x9;
  assign p.p22  = (x9 <<< 1) + (x1 <<< 2);
  assign p.p35  = (x1 <<< 5) + x3;
  assign p.p85  = (x5 <<< 4) + x5;
  assign p.p118 = (x1 <<< 7) - (x5 <<< 1);
  assign p.p207 = (x1 <<< 8) - (x3 <<< 4) - x1;

endmodule

// File: rtl/dwt4db_analysis.sv
// rtl/dwt4db_analysis.sv - db3 forward analysis bank, one (a,d) pair per two accepted samples
module dwt4db_analysis
  import dwt4db_analysis_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic        x_valid,
  output logic [15:0] a,
  output logic [15:0] d,
  output logic        ad_valid
);

  logic                    phase;
  logic [15:0]             x_even;
  logic signed [ACC_W-1:0] r1_a, r2_a, r1_d, r2_d;
  logic signed [ACC_W-1:0] acc_a, acc_d, n1_a, n2_a, n1_d, n2_d;
  rag_t                    po, pe;

  rag4db u_rag_odd  (.x(x),      .p(po));
  rag4db u_rag_even (.x(x_even), .p(pe));

  // Transposed polyphase form: r1/r2 carry the contributions of the previous
  // one and two pairs, so only the current pair needs multiplying.
  always_comb begin
    acc_a = ext(po.p85) + ext(pe.p207) + r1_a;
    n1_a  = ext(po.p118) - ext(pe.p35) + r2_a;
    n2_a  = ext(pe.p9) - ext(po.p22);
    acc_d = ext(po.p9) + ext(pe.p22) + r1_d;
    n1_d  = r2_d - ext(po.p35) - ext(pe.p118);
    n2_d  = ext(po.p207) - ext(pe.p85);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      x_even   <= '0;
      r1_a     <= '0;
      r2_a     <= '0;
      r1_d     <= '0;
      r2_d     <= '0;
      a        <= '0;
      d        <= '0;
      ad_valid <= 1'b0;
    end else begin
      ad_valid <= 1'b0;
      if (x_valid) begin
        if (!phase) begin
          x_even <= x;
          phase  <= 1'b1;
        end else begin
          phase    <= 1'b0;
          a        <= sat16(acc_a);
          d        <= sat16(acc_d);
          ad_valid <= 1'b1;
          r1_a     <= n1_a;
          r2_a     <= n2_a;
          r1_d     <= n1_d;
          r2_d     <= n2_d;
        end
      end
    end
  end

endmodule
